// File: rtl/fp16_mul_stream_pkg.sv
// Shared accelerator definitions for binary16 datapaths: field positions,
// special-value encodings, the operand-pair FIFO entry, and class helpers.
// No ports; imported by the streaming multiplier, its FIFO and the multiplier core.
package fp16_mul_stream_pkg;

  localparam int FP16_EXP_MSB = 14;
  localparam int FP16_EXP_LSB = 10;
  localparam int FP16_FRAC_W  = 10;
  localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

  // Canonical quiet NaN emitted by the multiplier core for any invalid result.
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // One buffered operand pair.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } pair_t;

  function automatic logic fp16_is_nan(input logic [15:0] x);
    return (x[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX) &&
           (x[FP16_FRAC_W-1:0] != '0);
  endfunction

  function automatic logic fp16_is_inf(input logic [15:0] x);
    return (x[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_MAX) &&
           (x[FP16_FRAC_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp16_mul_core.sv
// Purpose: combinational IEEE binary16 multiplier, round-to-nearest-even, with subnormals.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result follows the operands.
// Ports: a, b - binary16 operands; p - binary16 product (NaN results are 0x7E00).
module fp16_mul_core
  import fp16_mul_stream_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  logic [4:0]        ea, eb, ea_eff, eb_eff;
  logic [10:0]       ma, mb;
  logic [21:0]       m, mn, lost_mask;
  logic [4:0]        lz;
  logic              found;
  logic signed [7:0] be, sh8;
  logic [4:0]        sh;
  logic [20:0]       shifted;
  logic              lost, guard, sticky, inc;
  logic [4:0]        exp_f;
  logic [9:0]        frac;
  logic [14:0]       rounded;
  logic              sp, a_zero, b_zero;

  always_comb begin
    ea     = a[FP16_EXP_MSB:FP16_EXP_LSB];
    eb     = b[FP16_EXP_MSB:FP16_EXP_LSB];
    sp     = a[15] ^ b[15];
    a_zero = (ea == '0) && (a[FP16_FRAC_W-1:0] == '0);
    b_zero = (eb == '0) && (b[FP16_FRAC_W-1:0] == '0);
    // Subnormals share the exponent of the smallest normal, minus the hidden bit.
    ea_eff = (ea == '0) ? 5'd1 : ea;
    eb_eff = (eb == '0) ? 5'd1 : eb;
    ma     = {ea != '0, a[FP16_FRAC_W-1:0]};
    mb     = {eb != '0, b[FP16_FRAC_W-1:0]};
    m      = {11'd0, ma} * {11'd0, mb};

    // Normalise the raw product so its leading one sits at bit 21.
    lz    = '0;
    found = 1'b0;
    for (int i = 21; i >= 0; i--) begin
      if (!found && m[i]) begin
        lz    = 5'(21 - i);
        found = 1'b1;
      end
    end
    mn = m << lz;

    // Biased result exponent for a significand of the form 1.xxx at bit 21.
    be = $signed({3'b000, ea_eff}) + $signed({3'b000, eb_eff}) - 8'sd14
         - $signed({3'b000, lz});

    // Below the normal range, denormalise by shifting right; anything shifted
    // past the guard bit only contributes to sticky.
    sh8 = 8'sd1 - be;
    if (be >= 8'sd1)       sh = 5'd0;
    else if (sh8 > 8'sd22) sh = 5'd22;
    else                   sh = sh8[4:0];

    shifted   = 21'(mn >> sh);
    lost_mask = (22'd1 << sh) - 22'd1;
    lost      = |(mn & lost_mask);

    exp_f  = (be >= 8'sd1) ? be[4:0] : 5'd0;
    frac   = shifted[20:11];
    guard  = shifted[10];
    sticky = (|shifted[9:0]) | lost;
    inc    = guard & (sticky | frac[0]);
    // A rounding carry ripples into the exponent: subnormal->normal or max->inf.
    rounded = {exp_f, frac} + {14'd0, inc};

    if (fp16_is_nan(a) || fp16_is_nan(b) ||
        (fp16_is_inf(a) && b_zero) || (fp16_is_inf(b) && a_zero))
      p = FP16_QNAN;
    else if (fp16_is_inf(a) || fp16_is_inf(b))
      p = {sp, FP16_EXP_MAX, 10'd0};
    else if (a_zero || b_zero)
      p = {sp, 15'd0};
    else if (be > 8'sd30)
      p = {sp, FP16_EXP_MAX, 10'd0};
    else
      p = {sp, rounded};
  end

endmodule

// File: rtl/fp16_pair_fifo.sv
// Purpose: DEPTH-entry circular buffer of operand pairs.
// Latency: written entry visible at head the cycle after push; no bypass.
// Backpressure: full blocks pushes (caller gates push with !full); pop ignored when empty.
// Ports: clk, rst; push/push_data in; pop in; head out; full/empty status out.
module fp16_pair_fifo
  import fp16_mul_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pair_t push_data,
  input  logic  pop,
  output pair_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = $clog2(DEPTH);

  pair_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp16_mul_stream.sv
// Purpose: streams operand pairs through the binary16 multiplier core into a registered output.
// Latency: pair accepted at edge N -> out_valid after edge N+1 when the output register is free.
// Backpressure: out_ready low holds the output; FIFO absorbs DEPTH more pairs, then in_ready drops.
// Ports: in_valid/in_ready/in_a/in_b/in_last upstream; out_valid/out_ready/out_data/out_last
//        downstream; flag_clr in; flag_nan/flag_inf/flag_zero sticky and prod_cnt out.
module fp16_mul_stream
  import fp16_mul_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  input  logic             flag_clr,
  output logic             flag_nan,
  output logic             flag_inf,
  output logic             flag_zero,
  output logic [CNT_W-1:0] prod_cnt
);

  pair_t       push_pair, head;
  logic        fifo_full, fifo_empty;
  logic        push, pop, hs;
  logic [15:0] prod;
  logic        head_nan, head_inf;
  logic        mk_nan, mk_inf, mk_zero;

  // in_ready looks only at registered FIFO state, never at out_ready.
  assign in_ready  = ~fifo_full;
  assign push      = in_valid & in_ready;
  assign pop       = ~fifo_empty & (~out_valid | out_ready);
  assign hs        = out_valid & out_ready;
  assign push_pair = {in_a, in_b, in_last};

  fp16_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_pair),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  fp16_mul_core u_core (
    .a (head.a),
    .b (head.b),
    .p (prod)
  );

  // Operand classes travel with the product so flags reflect the delivered pair.
  assign head_nan = fp16_is_nan(head.a) | fp16_is_nan(head.b);
  assign head_inf = fp16_is_inf(head.a) | fp16_is_inf(head.b);
  assign mk_zero  = (out_data[14:0] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      mk_nan    <= 1'b0;
      mk_inf    <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= prod;
      out_last  <= head.last;
      mk_nan    <= head_nan;
      mk_inf    <= head_inf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A delivery coinciding with a clear is not lost: it becomes the first event
  // after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_nan  <= 1'b0;
      flag_inf  <= 1'b0;
      flag_zero <= 1'b0;
      prod_cnt  <= '0;
    end else if (flag_clr) begin
      flag_nan  <= hs & mk_nan;
      flag_inf  <= hs & mk_inf;
      flag_zero <= hs & mk_zero;
      prod_cnt  <= hs ? CNT_W'(1) : '0;
    end else if (hs) begin
      flag_nan  <= flag_nan  | mk_nan;
      flag_inf  <= flag_inf  | mk_inf;
      flag_zero <= flag_zero | mk_zero;
      prod_cnt  <= prod_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp16_mul_stream.sv
// Purpose: directed self-checking bench for fp16_mul_stream (CNT_W=4 to reach counter wrap).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per step to stall and release the output stream.
module tb_fp16_mul_stream;

  logic        clk, rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic        flag_clr, flag_nan, flag_inf, flag_zero;
  logic [3:0]  prod_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fp16_mul_stream #(.DEPTH(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .flag_clr  (flag_clr),
    .flag_nan  (flag_nan),
    .flag_inf  (flag_inf),
    .flag_zero (flag_zero),
    .prod_cnt  (prod_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one pair, wait for its product, and take it (optionally with flag_clr on that edge).
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic clr_at_hs,
                          output logic [15:0] d);
    int   w;
    logic to;
    to = 1'b0;
    out_ready = 1'b1;
    in_a = a; in_b = b; in_last = 1'b0; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin tick(); w++; end
    if (!in_ready) to = 1'b1;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin tick(); w++; end
    if (!out_valid) to = 1'b1;
    d = out_data;
    flag_clr = clr_at_hs;
    tick();
    flag_clr = 1'b0;
    chk("send_timeout", {31'd0, to}, 32'd0);
  endtask

  // Stream n pairs (1.0 x (0x3C00+i)) with out_ready high; collect last bits and data errors.
  task automatic stream(input int n, input int last_idx, output int got,
                        output logic [31:0] last_vec, output int data_err);
    int   sent;
    logic acc;
    sent = 0; got = 0; last_vec = '0; data_err = 0;
    out_ready = 1'b1;
    for (int c = 0; c < n * 2 + 20 && got < n; c++) begin
      if (sent < n) begin
        in_valid = 1'b1;
        in_a     = 16'h3C00;
        in_b     = 16'h3C00 + 16'(sent);
        in_last  = (sent == last_idx);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      acc = in_valid & in_ready;
      if (out_valid) begin
        if (out_data !== 16'h3C00 + 16'(got)) data_err++;
        if (got < 32) last_vec[got] = out_last;
        got++;
      end
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [15:0] d;
    logic [31:0] lv;
    int          got, derr, idx, stale;
    logic        acc, took6;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b0; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {16'd0, out_data},  32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_flags",     {29'd0, flag_nan, flag_inf, flag_zero}, 32'd0);
    chk("rst_cnt",       {28'd0, prod_cnt},  32'd0);
    rst = 1'b0;
    tick();

    // Basic product 1.0 x 2.0, checking the two-edge latency.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
    tick();
    in_valid = 1'b0;
    chk("basic_lat_n",   {31'd0, out_valid}, 32'd0);
    tick();
    chk("basic_valid",   {31'd0, out_valid}, 32'd1);
    chk("basic_data",    {16'd0, out_data},  32'h4000);
    chk("basic_last",    {31'd0, out_last},  32'd0);
    tick();
    chk("basic_drained", {31'd0, out_valid}, 32'd0);
    chk("basic_cnt",     {28'd0, prod_cnt},  32'd1);
    chk("basic_flags",   {29'd0, flag_nan, flag_inf, flag_zero}, 32'd0);

    // Backpressure: capacity is DEPTH+1 while the output is stalled.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00 + 16'(idx);
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted",   idx, 32'd5);
    chk("bp_in_ready",   {31'd0, in_ready},  32'd0);
    out_ready = 1'b1;
    took6 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data",  {16'd0, out_data},  32'h3C00 + k);
      acc = in_valid & in_ready;
      tick();
      if (acc) begin in_valid = 1'b0; took6 = 1'b1; end
    end
    chk("bp_sixth_taken", {31'd0, took6},     32'd1);
    chk("bp_empty",       {31'd0, out_valid}, 32'd0);
    chk("bp_cnt",         {28'd0, prod_cnt},  32'd7);

    // Exceptions.
    send_one(16'h7C00, 16'h3C00, 1'b0, d);
    chk("inf_data",  {16'd0, d},        32'h7C00);
    chk("inf_flag",  {31'd0, flag_inf}, 32'd1);
    chk("inf_nan0",  {31'd0, flag_nan}, 32'd0);
    send_one(16'h7E00, 16'h4000, 1'b0, d);
    chk("nan_data",  {16'd0, d},        32'h7E00);
    chk("nan_flag",  {31'd0, flag_nan}, 32'd1);
    chk("zero_pre",  {31'd0, flag_zero}, 32'd0);
    send_one(16'h0000, 16'h4500, 1'b0, d);
    chk("zero_data", {16'd0, d},         32'h0000);
    chk("zero_flag", {31'd0, flag_zero}, 32'd1);
    chk("exc_cnt",   {28'd0, prod_cnt},  32'd10);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("clr_flags", {29'd0, flag_nan, flag_inf, flag_zero}, 32'd0);
    chk("clr_cnt",   {28'd0, prod_cnt}, 32'd0);

    // Clear in the same cycle as delivering an inf pair: the delivery wins.
    send_one(16'h7C00, 16'h3C00, 1'b1, d);
    chk("coll_inf",  {31'd0, flag_inf}, 32'd1);
    chk("coll_nan",  {31'd0, flag_nan}, 32'd0);
    chk("coll_cnt",  {28'd0, prod_cnt}, 32'd1);

    // Vector of 8 with last on the 8th.
    stream(8, 7, got, lv, derr);
    chk("vec_got",   got,  32'd8);
    chk("vec_last",  lv,   32'h80);
    chk("vec_data",  derr, 32'd0);
    chk("vec_cnt",   {28'd0, prod_cnt}, 32'd9);

    // 17 products on a 4-bit counter wrap to 1.
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    stream(17, -1, got, lv, derr);
    chk("wrap_got",  got,  32'd17);
    chk("wrap_last", lv,   32'd0);
    chk("wrap_data", derr, 32'd0);
    chk("wrap_cnt",  {28'd0, prod_cnt}, 32'd1);

    // Reset mid-stream with three pairs buffered and a product held.
    send_one(16'h7C00, 16'h3C00, 1'b0, d);
    chk("pre_rst_inf", {31'd0, flag_inf}, 32'd1);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < 4; c++) begin
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000 + 16'(idx);
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("pre_rst_pushed", idx, 32'd4);
    chk("pre_rst_valid",  {31'd0, out_valid}, 32'd1);
    chk("pre_rst_cnt",    {28'd0, prod_cnt},  32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_flags", {29'd0, flag_nan, flag_inf, flag_zero}, 32'd0);
    chk("mid_rst_cnt",   {28'd0, prod_cnt},  32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) stale++;
      tick();
    end
    chk("post_rst_stale", stale, 32'd0);
    send_one(16'h3C00, 16'h4000, 1'b0, d);
    chk("post_rst_data", {16'd0, d},        32'h4000);
    chk("post_rst_cnt",  {28'd0, prod_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp16_mul_stream.md
# fp16_mul_stream

Streaming wrapper that feeds operand pairs into the team's combinational binary16 multiplier core and registers its products onto a valid/ready output stream. It sits between the accelerator's operand fetch unit (upstream) and the accumulate/writeback stage (downstream). Internally it provides input buffering, an output register, `last` propagation, a product counter, and sticky exception flags.

## Interface
- `DEPTH`, default 4: operand FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: product counter width.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept; equals `!fifo_full`.
- `in_a` in 16: binary16 operand A.
- `in_b` in 16: binary16 operand B.
- `in_last` in 1: marks final pair of a vector.
- `out_valid` out 1: product valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 16: binary16 product (A×B from multiplier core).
- `out_last` out 1: `in_last` of the same pair.
- `flag_clr` in 1: synchronous clear of flags and counter.
- `flag_nan` out 1: sticky; some delivered pair had a NaN operand (exp=31, frac≠0).
- `flag_inf` out 1: sticky; some delivered pair had an inf operand (exp=31, frac=0).
- `flag_zero` out 1: sticky; some delivered product had bits[14:0]=0.
- `prod_cnt` out CNT_W: number of products handed off downstream.

## Operation
- Push: `in_valid & in_ready` writes {a,b,last} at the write pointer.
- No full-bypass: `in_ready` depends only on the full state, even when a pop occurs in the same cycle.
- FIFO head drives the multiplier core combinationally.
- Output register load condition: `fifo_nonempty & (!out_valid | out_ready)`.
  - Loads `out_data`, `out_last`, and per-pair nan/inf markers.
  - Pops the FIFO head in the same cycle.
- Output handshake `out_valid & out_ready`:
  - `prod_cnt` += 1; wraps 2^CNT_W−1 → 0.
  - Flags OR in the markers of the delivered pair.
- `flag_clr`: flags and `prod_cnt` cleared. A set or increment in the same cycle wins.
  - Flag result = that pair's marker.
  - Counter result = 1.
- Pointers are log2(DEPTH) bits and wrap. An occupancy counter of log2(DEPTH)+1 bits gives full/empty.
- Simultaneous push and pop when not full and not empty: occupancy unchanged.
- Push into an empty FIFO: the entry is visible at the head the next cycle; there is no same-cycle bypass.
- Reset mid-stream:
  - FIFO flushed, pointers and occupancy to 0.
  - Output register invalidated; in-flight data discarded.
- Output reset values:
  - `in_ready`=1 (FIFO empty)
  - `out_valid`=0
  - `out_data`=0
  - `out_last`=0
  - all flags=0
  - `prod_cnt`=0
- No state machine beyond FIFO occupancy and the output-valid bit.

## Timing
- Latency: pair accepted at edge N → `out_valid`=1 after edge N+1, given the output register was free.
- Throughput: 1 product/cycle sustained while `out_ready`=1.
- `out_data`/`out_last` are held stable while `out_valid & !out_ready`.
- `in_ready` is a registered-state function only; it has no combinational path from `in_valid` or `out_ready`.
- Capacity under stall: DEPTH+1 pairs (DEPTH in FIFO, 1 in output register).
- Flags and counter update on the edge of the output handshake and are visible the following cycle.

## Structure
- Shared accelerator package:
  - binary16 field constants: `FP16_EXP_MSB`=14, `FP16_EXP_LSB`=10, `FP16_FRAC_W`=10, `FP16_EXP_MAX`=5'h1F.
  - FIFO entry typedef {a[15:0], b[15:0], last}.
- One sub-module, `fp16_pair_fifo`, parameterised by DEPTH.
  - Provides `push`, `pop`, `full`, `empty`, and head data.
- The existing multiplier core is instantiated unchanged.
- Classification logic (nan/inf detection on the head pair) is local to this block.

## Test plan
- Basic product: push (0x3C00, 0x4000), `out_ready`=1.
  - `out_valid` two edges after accept with `out_data`=0x4000.
  - `prod_cnt`=1; no flags set.
- Backpressure: hold `out_ready`=0, drive `in_valid`=1 with 6 pairs (0x3C00, 0x3C00+i).
  - Exactly 5 accepted, then `in_ready`=0.
  - Releasing `out_ready` drains 5 products in order at 1/cycle, then accepts the 6th.
- Exceptions:
  - (0x7C00, 0x3C00) → `out_data`=0x7C00, `flag_inf`=1.
  - (0x7E00, 0x4000) → `flag_nan`=1.
  - (0x0000, 0x4500) → `out_data`=0x0000, `flag_zero`=1.
  - `flag_clr` alone → all flags 0.
- Clear collision: `flag_clr` in the same cycle as delivery of an inf pair → `flag_inf`=1, `prod_cnt`=1.
- Last and wrap:
  - Vector of 8 pairs with `in_last` on the 8th → `out_last` only on the 8th product.
  - With CNT_W=4, 17 products → `prod_cnt`=1.
- Reset mid-stream: assert `rst` with 3 pairs buffered and `out_valid`=1.
  - Immediately `out_valid`=0, flags and counter 0.
  - After deassertion `in_ready`=1 and no stale product appears.
